// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
//
// Shared definitions for the interrupt controller:
//   - INT_VECTOR_DEFAULT : PC loaded when the ISR vector is taken
//   - FRAME_WORDS        : number of 16-bit stack words in one interrupt frame
//   - state_t            : sequencer states (entry push, vector, return pop)
//   - frame_t            : return context captured on interrupt entry
//   - push_word()        : selects the stack word for the current push state
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0020;
    localparam int          FRAME_WORDS        = 3;
    localparam int          CAP_CNT_W          = 2;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PUSH_HI  = 4'd1,
        PUSH_LO  = 4'd2,
        PUSH_FL  = 4'd3,
        VECTOR   = 4'd4,
        POP_FL   = 4'd5,
        POP_LO   = 4'd6,
        POP_HI   = 4'd7,
        POP_WAIT = 4'd8,
        RESTORE  = 4'd9
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  flags;
    } frame_t;

    // Stack word for a push state: PC high half, PC low half, then flags.
    function automatic logic [15:0] push_word(input state_t st, input frame_t fr);
        case (st)
            PUSH_HI: return fr.pc[31:16];
            PUSH_LO: return fr.pc[15:0];
            PUSH_FL: return {13'b0, fr.flags};
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Single-level interrupt sequencer for a pipelined processor. On a rising
// edge of interrupt_signal a request becomes pending; once no branch is in
// flight and no ISR is active, the return PC and flags are pushed to the
// stack as three 16-bit words, the PC is vectored to INT_VECTOR and the ISR
// is marked active. An RTI in decode while the ISR is active pops the three
// words back (flags, PC low, PC high) and restores PC and flags.
//
// Ports
//   clk               processor clock, all state changes on rising edge
//   rst               synchronous active-high reset; also forces outputs to 0
//   interrupt_signal  external request (rising edge sets pending)
//   branch_in_flight  taken jump/RET/RTI in decode/execute; defers entry
//   mem_busy          data port owned by memory stage; holds push/pop beats
//   rti_decoded       RTI present in decode
//   pc_current        PC of the next unexecuted instruction (return address)
//   flags_in          current flag register
//   mem_rdata         stack read data, valid one cycle after pop_en
//   stall_fetch       freeze PC and fetch register
//   flush_decode      turn decode output into a bubble
//   push_en/push_data stack push beat and its word
//   pop_en            stack pop beat
//   pc_load/pc_load_value       PC overwrite pulse and value
//   flags_restore/flags_out     flag register overwrite pulse and value
//   int_ack           one-cycle pulse when the vector is taken
//   in_isr            ISR active; masks further entries
// -----------------------------------------------------------------------------
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt_signal,
    input  logic        branch_in_flight,
    input  logic        mem_busy,
    input  logic        rti_decoded,
    input  logic [31:0] pc_current,
    input  logic [2:0]  flags_in,
    input  logic [15:0] mem_rdata,
    output logic        stall_fetch,
    output logic        flush_decode,
    output logic        push_en,
    output logic [15:0] push_data,
    output logic        pop_en,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        flags_restore,
    output logic [2:0]  flags_out,
    output logic        int_ack,
    output logic        in_isr
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;
    logic                  r_int_prev;
    logic                  r_pending;
    logic                  r_in_isr;
    logic                  r_rvalid;
    logic [CAP_CNT_W-1:0]  r_cap_cnt;
    frame_t                r_frame;
    logic [2:0]            r_cap_flags;
    logic [15:0]           r_cap_lo;
    logic [15:0]           r_cap_hi;

    // -------------------------------------------------------------------------
    // Decision terms
    // -------------------------------------------------------------------------
    logic w_rise;
    logic w_rti_take;
    logic w_enter;
    logic w_last_capture;
    logic w_frame_done;

    assign w_rise     = interrupt_signal & ~r_int_prev;

    // RTI outranks a pending request in the same IDLE cycle; the request
    // stays pending and is taken once the return sequence has finished.
    assign w_rti_take = (r_state == IDLE) & rti_decoded & r_in_isr;
    assign w_enter    = (r_state == IDLE) & r_pending & ~r_in_isr
                        & ~branch_in_flight & ~w_rti_take;

    assign w_last_capture = r_rvalid & (r_cap_cnt == CAP_CNT_W'(FRAME_WORDS - 1));
    // Covers the case where the final word landed while POP_WAIT was held
    // by mem_busy: the counter has already saturated at FRAME_WORDS.
    assign w_frame_done   = w_last_capture | (r_cap_cnt == CAP_CNT_W'(FRAME_WORDS));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_rti_take)   w_next_state = POP_FL;
                else if (w_enter) w_next_state = PUSH_HI;
            end
            PUSH_HI:  if (!mem_busy) w_next_state = PUSH_LO;
            PUSH_LO:  if (!mem_busy) w_next_state = PUSH_FL;
            PUSH_FL:  if (!mem_busy) w_next_state = VECTOR;
            VECTOR:   w_next_state = IDLE;
            POP_FL:   if (!mem_busy) w_next_state = POP_LO;
            POP_LO:   if (!mem_busy) w_next_state = POP_HI;
            POP_HI:   if (!mem_busy) w_next_state = POP_WAIT;
            POP_WAIT: if (!mem_busy && w_frame_done) w_next_state = RESTORE;
            RESTORE:  w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Edge detector history: tracks the input even during reset so a request
    // held high across reset does not look like a fresh edge afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        r_int_prev <= interrupt_signal;
    end

    // -------------------------------------------------------------------------
    // Sequencer, pending request, ISR flag and frame registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_in_isr    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_cap_cnt   <= '0;
            r_frame     <= '0;
            // NOTE: the capture slots are plain registers, not a RAM, so
            // resetting them is free and keeps the restore value defined.
            r_cap_flags <= '0;
            r_cap_lo    <= '0;
            r_cap_hi    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_rvalid <= pop_en;

            // A new edge coinciding with entry is a fresh request and wins.
            if (w_rise)       r_pending <= 1'b1;
            else if (w_enter) r_pending <= 1'b0;

            if (w_enter) r_frame <= '{pc: pc_current, flags: flags_in};

            if (r_state == VECTOR)       r_in_isr <= 1'b1;
            else if (r_state == RESTORE) r_in_isr <= 1'b0;

            // Read data arrives one cycle after its pop beat; the counter
            // names the slot in pop order: flags, PC low, PC high.
            if (w_rti_take) begin
                r_cap_cnt <= '0;
            end else if (r_rvalid && r_cap_cnt != CAP_CNT_W'(FRAME_WORDS)) begin
                case (r_cap_cnt)
                    2'd0:    r_cap_flags <= mem_rdata[2:0];
                    2'd1:    r_cap_lo    <= mem_rdata;
                    2'd2:    r_cap_hi    <= mem_rdata;
                    default: ;
                endcase
                r_cap_cnt <= r_cap_cnt + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode, with beats gated by mem_busy and everything
    // forced low while rst is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_fetch   = 1'b0;
        flush_decode  = 1'b0;
        push_en       = 1'b0;
        push_data     = 16'h0000;
        pop_en        = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 32'h0000_0000;
        flags_restore = 1'b0;
        flags_out     = 3'b000;
        int_ack       = 1'b0;
        in_isr        = 1'b0;

        if (!rst) begin
            in_isr       = r_in_isr;
            stall_fetch  = (r_state != IDLE);
            flush_decode = (r_state != IDLE);
            case (r_state)
                PUSH_HI, PUSH_LO, PUSH_FL: begin
                    push_en   = ~mem_busy;
                    push_data = push_word(r_state, r_frame);
                end
                VECTOR: begin
                    pc_load       = 1'b1;
                    pc_load_value = INT_VECTOR;
                    int_ack       = 1'b1;
                end
                POP_FL, POP_LO, POP_HI: begin
                    pop_en = ~mem_busy;
                end
                RESTORE: begin
                    pc_load       = 1'b1;
                    pc_load_value = {r_cap_hi, r_cap_lo};
                    flags_restore = 1'b1;
                    flags_out     = r_cap_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed bench for interrupt_controller. Expected stack words and PC/flag
// loads are queued when a request is stimulated and popped when the DUT
// emits a push beat or a pc_load pulse. A behavioural stack returns pushed
// words LIFO one cycle after each pop beat.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic        interrupt_signal;
    logic        branch_in_flight;
    logic        mem_busy;
    logic        rti_decoded;
    logic [31:0] pc_current;
    logic [2:0]  flags_in;
    logic [15:0] mem_rdata;
    logic        stall_fetch;
    logic        flush_decode;
    logic        push_en;
    logic [15:0] push_data;
    logic        pop_en;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        flags_restore;
    logic [2:0]  flags_out;
    logic        int_ack;
    logic        in_isr;

    interrupt_controller #(.INT_VECTOR(32'h0000_0020)) dut (
        .clk              (clk),
        .rst              (rst),
        .interrupt_signal (interrupt_signal),
        .branch_in_flight (branch_in_flight),
        .mem_busy         (mem_busy),
        .rti_decoded      (rti_decoded),
        .pc_current       (pc_current),
        .flags_in         (flags_in),
        .mem_rdata        (mem_rdata),
        .stall_fetch      (stall_fetch),
        .flush_decode     (flush_decode),
        .push_en          (push_en),
        .push_data        (push_data),
        .pop_en           (pop_en),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .flags_restore    (flags_restore),
        .flags_out        (flags_out),
        .int_ack          (int_ack),
        .in_isr           (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        ack;
        logic        fr;
        logic [2:0]  fl;
    } load_t;

    logic [15:0] exp_push[$];
    load_t       exp_load[$];
    logic [15:0] stack_q[$];
    int          push_cyc[$];

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int load_cnt = 0;
    int pop_cnt  = 0;
    int last_load_cycle = 0;
    int t0;
    int rs;

    logic [15:0] next_rdata;
    logic        snap_stall, snap_flush, snap_push_en, snap_pop_en;
    logic        snap_pc_load, snap_ack, snap_in_isr;
    logic [58:0] snap_all;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, called once per cycle at the falling edge.
    task automatic sample();
        load_t l;
        cycle++;
        snap_stall   = stall_fetch;
        snap_flush   = flush_decode;
        snap_push_en = push_en;
        snap_pop_en  = pop_en;
        snap_pc_load = pc_load;
        snap_ack     = int_ack;
        snap_in_isr  = in_isr;
        snap_all     = {stall_fetch, flush_decode, push_en, push_data, pop_en, pc_load,
                        pc_load_value, flags_restore, flags_out, int_ack, in_isr};
        if (push_en) begin
            push_cyc.push_back(cycle);
            stack_q.push_back(push_data);
            check("push_expected", 64'(exp_push.size() != 0), 64'd1);
            if (exp_push.size() != 0) check("push_data", 64'(push_data), 64'(exp_push.pop_front()));
        end
        if (pc_load) begin
            load_cnt++;
            last_load_cycle = cycle;
            check("load_expected", 64'(exp_load.size() != 0), 64'd1);
            if (exp_load.size() != 0) begin
                l = exp_load.pop_front();
                check("load_pc", 64'(pc_load_value), 64'(l.pc));
                check("load_ack", 64'(int_ack), 64'(l.ack));
                check("load_flags", 64'({flags_restore, flags_out}), 64'({l.fr, l.fl}));
            end
        end else if (int_ack || flags_restore) begin
            check("pulse_without_load", 64'({int_ack, flags_restore}), 64'd0);
        end
        if (pop_en) begin
            pop_cnt++;
            next_rdata = (stack_q.size() != 0) ? stack_q.pop_back() : 16'hEEEE;
        end else begin
            next_rdata = 16'hA5A5;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        mem_rdata = next_rdata;
    endtask

    task automatic wait_load(input string tag, input int budget);
        int start = load_cnt;
        int n = 0;
        while (load_cnt == start && n < budget) begin
            cyc();
            n++;
        end
        check(tag, 64'(load_cnt != start), 64'd1);
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [2:0] fl);
        exp_push.push_back(pc[31:16]);
        exp_push.push_back(pc[15:0]);
        exp_push.push_back({13'b0, fl});
        exp_load.push_back('{pc: 32'h0000_0020, ack: 1'b1, fr: 1'b0, fl: 3'b000});
    endtask

    task automatic expect_return(input logic [31:0] pc, input logic [2:0] fl);
        exp_load.push_back('{pc: pc, ack: 1'b0, fr: 1'b1, fl: fl});
    endtask

    initial begin
        rst = 1'b1;
        interrupt_signal = 1'b0;
        branch_in_flight = 1'b0;
        mem_busy = 1'b0;
        rti_decoded = 1'b0;
        pc_current = 32'h0;
        flags_in = 3'b000;
        mem_rdata = 16'h0;
        next_rdata = 16'hA5A5;

        // Reset: every output low.
        cyc();
        cyc();
        check("reset_outputs", 64'(snap_all), 64'd0);
        rst = 1'b0;
        cyc();
        check("idle_outputs", 64'(snap_all), 64'd0);

        // Nominal entry: pushes at +2..+4, vector at +5, idle with in_isr at +6.
        pc_current = 32'h0001_0004;
        flags_in = 3'b101;
        expect_entry(32'h0001_0004, 3'b101);
        push_cyc.delete();
        interrupt_signal = 1'b1;
        cyc();
        t0 = cycle;
        interrupt_signal = 1'b0;
        cyc();
        check("pending_no_stall", 64'(snap_stall), 64'd0);
        pc_current = 32'hDEAD_BEEF;
        flags_in = 3'b010;
        cyc();
        check("push_hi_stall_flush", 64'({snap_stall, snap_flush, snap_push_en}), 64'b111);
        wait_load("entry_timeout", 10);
        check("ack_cycle", 64'(last_load_cycle - t0), 64'd5);
        check("push_count", 64'(push_cyc.size()), 64'd3);
        if (push_cyc.size() == 3) begin
            check("push_first_cycle", 64'(push_cyc[0] - t0), 64'd2);
            check("push_last_cycle", 64'(push_cyc[2] - t0), 64'd4);
        end
        cyc();
        check("after_vector", 64'({snap_ack, snap_stall, snap_in_isr}), 64'b001);

        // Return: stack yields 0005, 0004, 0001; restore five cycles after RTI.
        expect_return(32'h0001_0004, 3'b101);
        rti_decoded = 1'b1;
        cyc();
        t0 = cycle;
        rti_decoded = 1'b0;
        wait_load("rti_timeout", 10);
        check("rti_cycle", 64'(last_load_cycle - t0), 64'd5);
        cyc();
        check("after_restore", 64'({snap_in_isr, snap_stall}), 64'b00);

        // RTI outside an ISR is ignored.
        rs = pop_cnt;
        rti_decoded = 1'b1;
        cyc();
        rti_decoded = 1'b0;
        cyc();
        cyc();
        check("rti_ignored", 64'({snap_stall, 1'(pop_cnt != rs)}), 64'd0);

        // branch_in_flight for three cycles delays entry by three.
        pc_current = 32'h1234_5678;
        flags_in = 3'b010;
        expect_entry(32'h1234_5678, 3'b010);
        push_cyc.delete();
        interrupt_signal = 1'b1;
        cyc();
        t0 = cycle;
        interrupt_signal = 1'b0;
        branch_in_flight = 1'b1;
        cyc();
        cyc();
        cyc();
        check("branch_hold", 64'(snap_stall), 64'd0);
        branch_in_flight = 1'b0;
        wait_load("branch_entry_timeout", 12);
        check("branch_ack_cycle", 64'(last_load_cycle - t0), 64'd8);
        if (push_cyc.size() != 0) check("branch_push_cycle", 64'(push_cyc[0] - t0), 64'd5);
        expect_return(32'h1234_5678, 3'b010);
        rti_decoded = 1'b1;
        cyc();
        rti_decoded = 1'b0;
        wait_load("branch_rti_timeout", 10);

        // mem_busy during PUSH_LO for two cycles, then during POP_LO for one.
        pc_current = 32'hCAFE_0001;
        flags_in = 3'b111;
        expect_entry(32'hCAFE_0001, 3'b111);
        push_cyc.delete();
        interrupt_signal = 1'b1;
        cyc();
        t0 = cycle;
        interrupt_signal = 1'b0;
        cyc();
        cyc();
        mem_busy = 1'b1;
        cyc();
        check("busy_push_held1", 64'({snap_push_en, snap_stall}), 64'b01);
        cyc();
        check("busy_push_held2", 64'({snap_push_en, snap_stall}), 64'b01);
        mem_busy = 1'b0;
        wait_load("busy_entry_timeout", 12);
        check("busy_ack_cycle", 64'(last_load_cycle - t0), 64'd7);
        check("busy_push_count", 64'(push_cyc.size()), 64'd3);
        expect_return(32'hCAFE_0001, 3'b111);
        rti_decoded = 1'b1;
        cyc();
        t0 = cycle;
        rti_decoded = 1'b0;
        cyc();
        check("pop_fl_beat", 64'(snap_pop_en), 64'd1);
        mem_busy = 1'b1;
        cyc();
        check("busy_pop_held", 64'({snap_pop_en, snap_stall}), 64'b01);
        mem_busy = 1'b0;
        wait_load("busy_rti_timeout", 12);
        check("busy_rti_cycle", 64'(last_load_cycle - t0), 64'd6);

        // Request during ISR is masked; RTI wins; request enters after RESTORE.
        pc_current = 32'h0000_1000;
        flags_in = 3'b001;
        expect_entry(32'h0000_1000, 3'b001);
        interrupt_signal = 1'b1;
        cyc();
        interrupt_signal = 1'b0;
        wait_load("nest_entry_timeout", 10);
        pc_current = 32'h0000_2000;
        flags_in = 3'b011;
        interrupt_signal = 1'b1;
        cyc();
        interrupt_signal = 1'b0;
        cyc();
        cyc();
        check("masked_in_isr", 64'({snap_stall, snap_in_isr}), 64'b01);
        expect_return(32'h0000_1000, 3'b001);
        expect_entry(32'h0000_2000, 3'b011);
        push_cyc.delete();
        rti_decoded = 1'b1;
        cyc();
        t0 = cycle;
        rti_decoded = 1'b0;
        wait_load("nest_rti_timeout", 10);
        check("nest_rti_cycle", 64'(last_load_cycle - t0), 64'd5);
        rs = last_load_cycle;
        wait_load("nest_pending_timeout", 12);
        if (push_cyc.size() != 0) check("pending_after_restore", 64'(push_cyc[0] - rs), 64'd2);
        check("pending_ack_cycle", 64'(last_load_cycle - rs), 64'd5);
        expect_return(32'h0000_2000, 3'b011);
        rti_decoded = 1'b1;
        cyc();
        rti_decoded = 1'b0;
        wait_load("nest_rti2_timeout", 10);

        // Reset in PUSH_LO abandons the frame.
        pc_current = 32'hFFFF_FFFF;
        flags_in = 3'b111;
        exp_push.push_back(16'hFFFF);
        push_cyc.delete();
        rs = load_cnt;
        interrupt_signal = 1'b1;
        cyc();
        interrupt_signal = 1'b0;
        cyc();
        cyc();
        check("pre_reset_push", 64'(snap_push_en), 64'd1);
        rst = 1'b1;
        cyc();
        check("reset_in_push_lo", 64'(snap_all), 64'd0);
        rst = 1'b0;
        cyc();
        check("after_reset_idle", 64'(snap_all), 64'd0);
        for (int i = 0; i < 8; i++) cyc();
        check("no_push_after_reset", 64'(push_cyc.size()), 64'd1);
        check("no_load_after_reset", 64'(load_cnt - rs), 64'd0);

        check("push_queue_drained", 64'(exp_push.size()), 64'd0);
        check("load_queue_drained", 64'(exp_load.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
